qam16_symbol_mapper: RTL and testbench

// Upstream feeder for the QAM16 shaping/DAC path. It collects a serial payload bit stream into 4-bit symbols and

---
 rtl/qam16_symbol_mapper.sv | 151 +++++++++++++++
 tb/tb_qam16_symbol_mapper.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qam16_symbol_mapper.sv
// QAM16 symbol mapper: collects serial bits into nibbles, Gray-maps them to I/Q levels,
// and emits one registered, zero-stuffed impulse every SPS clocks for the shaping filter.
module qam16_symbol_mapper #(
    parameter int DW  = 8,
    parameter int AMP = 32,
    parameter int SPS = 8
) (
    input  logic                 CLK,
    input  logic                 Rst,
    input  logic                 en,
    input  logic                 bit_in,
    input  logic                 bit_valid,
    output logic                 bit_ready,
    output logic signed [DW-1:0] i_out,
    output logic signed [DW-1:0] q_out,
    output logic                 sym_strobe,
    output logic                 underrun
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam logic [7:0]           PHASE_LAST = 8'(SPS - 1);
    localparam logic signed [DW-1:0] LVL_1      = DW'(AMP);
    localparam logic signed [DW-1:0] LVL_3      = DW'(3 * AMP);

    // Gray order keeps adjacent constellation points one bit apart.
    function automatic logic signed [DW-1:0] gray_level(input logic [1:0] g);
        unique case (g)
            2'b00:   return -LVL_3;
            2'b01:   return -LVL_1;
            2'b11:   return LVL_1;
            default: return LVL_3;
        endcase
    endfunction

    state_t                state_q, state_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [2:0]            shreg_q, shreg_d;
    logic [3:0]            nibble_q, nibble_d;
    logic                  nib_full_q, nib_full_d;
    logic [7:0]            phase_q, phase_d;
    logic signed [DW-1:0]  i_q, i_d;
    logic signed [DW-1:0]  q_q, q_d;
    logic                  strobe_q, strobe_d;
    logic                  under_q, under_d;

    logic slot;
    logic consume;
    logic accept;

    assign slot      = (state_q == RUN) && (phase_q == 8'd0);
    assign consume   = slot && nib_full_q;
    assign bit_ready = (state_q != IDLE) && (!nib_full_q || consume);
    assign accept    = bit_valid && bit_ready;

    // NOTE: every next-state signal takes its hold/default value first, so no path leaves one unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shreg_d    = shreg_q;
        nibble_d   = nibble_q;
        nib_full_d = nib_full_q;
        phase_d    = phase_q;
        i_d        = '0;
        q_d        = '0;
        strobe_d   = 1'b0;
        under_d    = 1'b0;

        unique case (state_q)
            IDLE:    if (en) state_d = FILL;
            FILL:    if (accept && cnt_q == 2'd3) state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = IDLE;
        endcase

        if (state_q == RUN) begin
            phase_d = (phase_q == PHASE_LAST) ? 8'd0 : phase_q + 8'd1;
        end

        // Consume first so a nibble completing in the same cycle keeps nib_full set.
        if (consume) nib_full_d = 1'b0;
        if (accept) begin
            if (cnt_q == 2'd3) begin
                nibble_d   = {shreg_q, bit_in};
                nib_full_d = 1'b1;
                cnt_d      = 2'd0;
            end else begin
                shreg_d = {shreg_q[1:0], bit_in};
                cnt_d   = cnt_q + 2'd1;
            end
        end

        if (consume) begin
            i_d      = gray_level(nibble_q[3:2]);
            q_d      = gray_level(nibble_q[1:0]);
            strobe_d = 1'b1;
        end else if (slot) begin
            under_d = 1'b1;
        end

        if (!en) begin
            state_d    = IDLE;
            cnt_d      = 2'd0;
            shreg_d    = 3'd0;
            nibble_d   = 4'd0;
            nib_full_d = 1'b0;
            phase_d    = 8'd0;
            i_d        = '0;
            q_d        = '0;
            strobe_d   = 1'b0;
            under_d    = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge CLK or negedge Rst) begin
        if (!Rst) begin
            state_q    <= IDLE;
            cnt_q      <= 2'd0;
            shreg_q    <= 3'd0;
            nibble_q   <= 4'd0;
            nib_full_q <= 1'b0;
            phase_q    <= 8'd0;
            i_q        <= '0;
            q_q        <= '0;
            strobe_q   <= 1'b0;
            under_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shreg_q    <= shreg_d;
            nibble_q   <= nibble_d;
            nib_full_q <= nib_full_d;
            phase_q    <= phase_d;
            i_q        <= i_d;
            q_q        <= q_d;
            strobe_q   <= strobe_d;
            under_q    <= under_d;
        end
    end

    assign i_out      = i_q;
    assign q_out      = q_q;
    assign sym_strobe = strobe_q;
    assign underrun   = under_q;

endmodule

// File: tb/tb_qam16_symbol_mapper.sv
// Directed bench for qam16_symbol_mapper: one instance at SPS=8 and one at SPS=4,
// each fed from a bit queue honouring bit_ready, with an event monitor sampling on the falling edge.
module tb_qam16_symbol_mapper;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic              en8, bi8, bv8, rdy8, strobe8, under8;
    logic signed [7:0] i8, q8;
    logic              en4, bi4, bv4, rdy4, strobe4, under4;
    logic signed [7:0] i4, q4;

    qam16_symbol_mapper #(.DW(8), .AMP(32), .SPS(8)) u_dut (
        .CLK(clk), .Rst(rst_n), .en(en8), .bit_in(bi8), .bit_valid(bv8), .bit_ready(rdy8),
        .i_out(i8), .q_out(q8), .sym_strobe(strobe8), .underrun(under8)
    );

    qam16_symbol_mapper #(.DW(8), .AMP(32), .SPS(4)) u_dut4 (
        .CLK(clk), .Rst(rst_n), .en(en4), .bit_in(bi4), .bit_valid(bv4), .bit_ready(rdy4),
        .i_out(i4), .q_out(q4), .sym_strobe(strobe4), .underrun(under4)
    );

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    logic src8[$];
    logic src4[$];
    int   st_cyc[$];
    int   st_i[$];
    int   st_q[$];
    int   un_cyc[$];
    int   st4_cyc[$];
    int   st4_i[$];
    int   st4_q[$];
    int   un4       = 0;
    int   rdy4_low  = 0;
    int   zero_viol = 0;
    logic win4      = 1'b0;

    // Gray levels at AMP=32, indexed by the 2-bit code.
    int lvl[4] = '{-96, -32, 96, 32};

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push8(input logic [3:0] n);
        for (int b = 3; b >= 0; b--) src8.push_back(n[b]);
    endtask

    task automatic push4(input logic [3:0] n);
        for (int b = 3; b >= 0; b--) src4.push_back(n[b]);
    endtask

    task automatic wait_st8(input int n, input int budget, input string tag);
        int k = 0;
        while (st_cyc.size() < n && k < budget) begin
            tick();
            k++;
        end
        check(tag, int'(st_cyc.size() >= n), 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en8   = 1'b0;
        en4   = 1'b0;
        win4  = 1'b0;
        src8.delete();
        src4.delete();
        st_cyc.delete();
        st_i.delete();
        st_q.delete();
        un_cyc.delete();
        st4_cyc.delete();
        st4_i.delete();
        st4_q.delete();
        un4      = 0;
        rdy4_low = 0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    always @(posedge clk) cyc++;

    // Bit sources: handshake sampled on the falling edge, queue advanced on the rising edge.
    initial begin
        logic hs8, hs4;
        bv8 = 1'b0; bi8 = 1'b0; bv4 = 1'b0; bi4 = 1'b0;
        forever begin
            @(negedge clk);
            hs8 = bv8 && rdy8;
            hs4 = bv4 && rdy4;
            @(posedge clk);
            if (hs8 && src8.size() > 0) void'(src8.pop_front());
            if (hs4 && src4.size() > 0) void'(src4.pop_front());
            #1;
            bv8 = (src8.size() > 0);
            bi8 = (src8.size() > 0) ? src8[0] : 1'b0;
            bv4 = (src4.size() > 0);
            bi4 = (src4.size() > 0) ? src4[0] : 1'b0;
        end
    end

    always @(negedge clk) begin
        if (strobe8) begin
            st_cyc.push_back(cyc);
            st_i.push_back(int'(i8));
            st_q.push_back(int'(q8));
        end
        if (under8) un_cyc.push_back(cyc);
        if (!strobe8 && (i8 != 0 || q8 != 0)) zero_viol++;
        if (strobe8 && under8) zero_viol++;
        if (strobe4) begin
            st4_cyc.push_back(cyc);
            st4_i.push_back(int'(i4));
            st4_q.push_back(int'(q4));
        end
        if (under4) un4++;
        if (win4 && src4.size() > 0 && !rdy4) rdy4_low++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t_en;
        int s2;
        int k;
        logic [3:0] pat4[10] = '{4'd5, 4'd10, 4'd15, 4'd0, 4'd3, 4'd12, 4'd6, 4'd9, 4'd1, 4'd14};

        // Reset state
        do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_i", int'(i8), 0);
        check("rst_q", int'(q8), 0);
        check("rst_strobe", int'(strobe8), 0);
        check("rst_underrun", int'(under8), 0);
        check("rst_ready", int'(rdy8), 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("idle_ready", int'(rdy8), 0);

        // Mapping 0000 then 1010, 8 clocks apart
        do_reset();
        push8(4'b0000);
        push8(4'b1010);
        en8  = 1'b1;
        t_en = cyc;
        wait_st8(2, 60, "t2_wait");
        en8 = 1'b0;
        if (st_cyc.size() >= 2) begin
            check("t2_latency", st_cyc[0] - t_en, 6);
            check("t2_i0", st_i[0], -96);
            check("t2_q0", st_q[0], -96);
            check("t2_i1", st_i[1], 96);
            check("t2_q1", st_q[1], 96);
            check("t2_gap", st_cyc[1] - st_cyc[0], 8);
        end
        check("t2_underruns", un_cyc.size(), 0);

        // All 16 nibbles
        do_reset();
        for (int n = 0; n < 16; n++) push8(4'(n));
        en8 = 1'b1;
        wait_st8(16, 400, "t3_wait");
        en8 = 1'b0;
        check("t3_count", st_cyc.size(), 16);
        for (int n = 0; n < st_i.size(); n++) begin
            check($sformatf("t3_i%0d", n), st_i[n], lvl[n >> 2]);
            check($sformatf("t3_q%0d", n), st_q[n], lvl[n & 3]);
        end
        if (st_cyc.size() >= 16) check("t3_span", st_cyc[15] - st_cyc[0], 120);
        check("t3_underruns", un_cyc.size(), 0);

        // Starved source
        do_reset();
        push8(4'b0101);
        push8(4'b1101);
        en8 = 1'b1;
        wait_st8(2, 60, "t4_wait2");
        s2 = (st_cyc.size() >= 2) ? st_cyc[1] : cyc;
        repeat (30) tick();
        push8(4'b1000);
        wait_st8(3, 60, "t4_wait3");
        en8 = 1'b0;
        if (st_cyc.size() >= 3) begin
            check("t4_i1", st_i[1], 32);
            check("t4_q1", st_q[1], -32);
            check("t4_resume_cyc", st_cyc[2] - s2, 40);
            check("t4_resume_i", st_i[2], 96);
            check("t4_resume_q", st_q[2], -96);
        end
        check("t4_underruns", un_cyc.size(), 4);
        if (un_cyc.size() >= 4) begin
            check("t4_un_first", un_cyc[0] - s2, 8);
            check("t4_un_last", un_cyc[3] - s2, 32);
        end

        // Backpressure at SPS=4
        do_reset();
        for (int n = 0; n < 10; n++) push4(pat4[n]);
        en4 = 1'b1;
        tick();
        win4 = 1'b1;
        k = 0;
        while (st4_cyc.size() < 10 && k < 200) begin
            tick();
            k++;
        end
        en4 = 1'b0;
        check("t5_count", st4_cyc.size(), 10);
        check("t5_ready_low", rdy4_low, 0);
        check("t5_underruns", un4, 0);
        if (st4_cyc.size() >= 10) begin
            check("t5_span", st4_cyc[9] - st4_cyc[0], 36);
            check("t5_i0", st4_i[0], -32);
            check("t5_q0", st4_q[0], -32);
            check("t5_i9", st4_i[9], 32);
            check("t5_q9", st4_q[9], 96);
        end

        // en dropped after two bits
        do_reset();
        src8.push_back(1'b1);
        src8.push_back(1'b1);
        en8 = 1'b1;
        k = 0;
        while (src8.size() > 0 && k < 20) begin
            tick();
            k++;
        end
        check("t6_partial_taken", src8.size(), 0);
        en8 = 1'b0;
        tick();
        tick();
        check("t6_idle_ready", int'(rdy8), 0);
        push8(4'b0101);
        en8 = 1'b1;
        wait_st8(1, 60, "t6_wait");
        en8 = 1'b0;
        if (st_cyc.size() >= 1) begin
            check("t6_i", st_i[0], -32);
            check("t6_q", st_q[0], -32);
        end
        check("t6_underruns", un_cyc.size(), 0);

        // Reset mid-RUN while strobe is high
        do_reset();
        push8(4'b1111);
        push8(4'b0000);
        en8 = 1'b1;
        wait_st8(1, 60, "t1_wait");
        check("t1_pre_strobe", int'(strobe8), 1);
        rst_n = 1'b0;
        #1;
        check("t1_i", int'(i8), 0);
        check("t1_q", int'(q8), 0);
        check("t1_strobe", int'(strobe8), 0);
        check("t1_underrun", int'(under8), 0);
        check("t1_ready", int'(rdy8), 0);
        tick();
        check("t1_ready_held", int'(rdy8), 0);
        rst_n = 1'b1;
        en8   = 1'b0;
        tick();

        check("zeros_between", zero_viol, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
